// File: rtl/mlp_result_reader.sv
// Drains the MLP final-layer result vector from the X buffer and streams it to the host
// through a 2-entry prefetch FIFO that hides the 1-cycle RAM read latency.
//   state   | meaning
//   S_IDLE  | waiting for result_valid_i
//   S_READ  | issuing X-buffer reads while FIFO space allows
//   S_DRAIN | all reads issued, waiting for the last handshake
module mlp_result_reader #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int OUT_LEN  = 10,
    parameter int RES_BASE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              result_valid_i,
    input  logic              x_sel_i,
    output logic              busy_o,
    output logic              x_ren_o,
    output logic              x_sel_o,
    output logic [ADDR_W-1:0] x_addr_o,
    input  logic [DATA_W-1:0] x_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_idx_o,
    output logic              out_last_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [ADDR_W:0]   LEN_C  = (ADDR_W + 1)'(OUT_LEN);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(OUT_LEN - 1);
    localparam logic [ADDR_W-1:0] BASE_C = ADDR_W'(RES_BASE);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   issue_cnt;
    logic [ADDR_W-1:0] pop_cnt;
    logic              bank_q;
    logic              inflight_q;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;
    logic [2:0]        occ;
    logic              pop;
    logic              accept;

    assign out_valid_o = (fifo_cnt != 2'd0);
    assign pop         = out_valid_o & out_ready_i;
    assign out_data_o  = out_valid_o ? fifo_mem[rd_ptr] : '0;
    assign out_idx_o   = out_valid_o ? pop_cnt : '0;
    assign out_last_o  = out_valid_o & (pop_cnt == LAST_C);
    assign x_sel_o     = bank_q;
    // A trigger in the done_o cycle still belongs to the finishing drain.
    assign accept      = (state_q == S_IDLE) & result_valid_i & ~done_o;
    assign occ         = {1'b0, fifo_cnt} + {2'b00, inflight_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != S_IDLE);
            done_o  <= (state_q == S_DRAIN) & pop & out_last_o;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  if (issue_cnt == LEN_C) state_d = S_DRAIN;
            S_DRAIN: if (pop && out_last_o) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Words held plus the read in flight, less this cycle's pop, must stay below 2.
    always_comb begin
        x_ren_o  = 1'b0;
        x_addr_o = '0;
        if (state_q == S_READ && issue_cnt < LEN_C && occ < (3'd2 + {2'b00, pop})) begin
            x_ren_o  = 1'b1;
            x_addr_o = BASE_C + issue_cnt[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            issue_cnt  <= '0;
            pop_cnt    <= '0;
            bank_q     <= 1'b0;
            inflight_q <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
            err_o      <= 1'b0;
        end else begin
            inflight_q <= x_ren_o;
            if (result_valid_i && (state_q != S_IDLE || done_o)) err_o <= 1'b1;
            if (accept) begin
                issue_cnt <= '0;
                pop_cnt   <= '0;
                bank_q    <= x_sel_i;
            end else begin
                if (x_ren_o) issue_cnt <= issue_cnt + 1'b1;
                if (pop)     pop_cnt   <= pop_cnt + 1'b1;
            end
            if (inflight_q) wr_ptr <= ~wr_ptr;
            if (pop)        rd_ptr <= ~rd_ptr;
            case ({inflight_q, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (inflight_q) fifo_mem[wr_ptr] <= x_rdata_i;
    end

endmodule

// File: tb/tb_mlp_result_reader.sv
// Bench for mlp_result_reader: three instances (default, RES_BASE=4, OUT_LEN=1) driven by
// directed drains with fixed and random backpressure, checked against the expected word stream.
module tb_mlp_result_reader;

    logic        clk;
    logic        rst [3];
    logic        rv [3];
    logic        xs [3];
    logic        rdy [3];
    logic        busy [3];
    logic        ren [3];
    logic        xsel [3];
    logic [7:0]  addr [3];
    logic [15:0] rdata [3];
    logic        ov [3];
    logic [15:0] odata [3];
    logic [7:0]  idx [3];
    logic        last [3];
    logic        done [3];
    logic        err [3];

    logic [15:0] ram [3][2][256];
    int          len_of [3];
    int          base_of [3];
    logic        err_exp [3];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mlp_result_reader #(.DATA_W(16), .ADDR_W(8), .OUT_LEN(10), .RES_BASE(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst[0]), .result_valid_i(rv[0]), .x_sel_i(xs[0]),
        .busy_o(busy[0]), .x_ren_o(ren[0]), .x_sel_o(xsel[0]), .x_addr_o(addr[0]),
        .x_rdata_i(rdata[0]), .out_valid_o(ov[0]), .out_ready_i(rdy[0]),
        .out_data_o(odata[0]), .out_idx_o(idx[0]), .out_last_o(last[0]),
        .done_o(done[0]), .err_o(err[0]));

    mlp_result_reader #(.DATA_W(16), .ADDR_W(8), .OUT_LEN(10), .RES_BASE(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst[1]), .result_valid_i(rv[1]), .x_sel_i(xs[1]),
        .busy_o(busy[1]), .x_ren_o(ren[1]), .x_sel_o(xsel[1]), .x_addr_o(addr[1]),
        .x_rdata_i(rdata[1]), .out_valid_o(ov[1]), .out_ready_i(rdy[1]),
        .out_data_o(odata[1]), .out_idx_o(idx[1]), .out_last_o(last[1]),
        .done_o(done[1]), .err_o(err[1]));

    mlp_result_reader #(.DATA_W(16), .ADDR_W(8), .OUT_LEN(1), .RES_BASE(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst[2]), .result_valid_i(rv[2]), .x_sel_i(xs[2]),
        .busy_o(busy[2]), .x_ren_o(ren[2]), .x_sel_o(xsel[2]), .x_addr_o(addr[2]),
        .x_rdata_i(rdata[2]), .out_valid_o(ov[2]), .out_ready_i(rdy[2]),
        .out_data_o(odata[2]), .out_idx_o(idx[2]), .out_last_o(last[2]),
        .done_o(done[2]), .err_o(err[2]));

    // X-buffer stand-in: data one cycle after the read enable, junk otherwise.
    always @(posedge clk) begin
        for (int j = 0; j < 3; j++)
            rdata[j] <= ren[j] ? ram[j][xsel[j]][addr[j]] : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk({tag, "_busy"},  32'(busy[k]),  0);
        chk({tag, "_ren"},   32'(ren[k]),   0);
        chk({tag, "_xsel"},  32'(xsel[k]),  0);
        chk({tag, "_addr"},  32'(addr[k]),  0);
        chk({tag, "_valid"}, 32'(ov[k]),    0);
        chk({tag, "_data"},  32'(odata[k]), 0);
        chk({tag, "_idx"},   32'(idx[k]),   0);
        chk({tag, "_last"},  32'(last[k]),  0);
        chk({tag, "_done"},  32'(done[k]),  0);
        chk({tag, "_err"},   32'(err[k]),   0);
    endtask

    // mode 0: ready always 1, 1: ready 0 for cycles 0..20, 2: toggling, 3: random.
    // trig2 / rst_at: cycle of a second trigger / a reset pulse, -1 for none.
    task automatic run_drain(input int k, input logic sel, input int mode,
                             input int trig2, input int rst_at);
        int          len = len_of[k];
        int          base = base_of[k];
        int          issued = 0;
        int          popped = 0;
        int          last_hs = -1;
        bit          fin = 0;
        bit          hold = 0;
        logic [15:0] hold_d = '0;
        logic [7:0]  hold_i = '0;
        logic        r;
        bit          busy_e, done_e;
        for (int c = 0; c < 300 && !fin; c++) begin
            @(posedge clk);
            #1;
            for (int j = 0; j < 3; j++) if (j != k) rv[j] = 1'b0;
            rv[k]  = (c == 0) || (c == trig2);
            xs[k]  = (c == 0) ? sel : ~sel;
            rst[k] = (c == rst_at);
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = (c > 20);
            else if (mode == 2) r = (c % 2 == 0);
            else                r = 1'($urandom);
            rdy[k] = r;
            @(negedge clk);

            if (rst_at >= 0 && c > rst_at) begin
                if (c == rst_at + 1) chk_zero(k, "after_reset");
                else begin
                    chk("post_reset_ren",  32'(ren[k]),  0);
                    chk("post_reset_done", 32'(done[k]), 0);
                    chk("post_reset_busy", 32'(busy[k]), 0);
                end
                if (c == rst_at + 6) fin = 1;
                continue;
            end

            busy_e = (c >= 1) && (last_hs < 0 || c <= last_hs);
            done_e = (last_hs >= 0) && (c == last_hs + 1);
            chk("busy", 32'(busy[k]), 32'(busy_e));
            chk("done", 32'(done[k]), 32'(done_e));
            chk("err",  32'(err[k]),  32'(err_exp[k]));
            if (mode == 0) begin
                chk("ren_timing",   32'(ren[k]), 32'((c >= 1) && (c <= len)));
                chk("valid_timing", 32'(ov[k]),  32'((c >= 3) && (c <= len + 2)));
            end
            if (ren[k] === 1'b1) begin
                chk("read_addr",  32'(addr[k]), 32'(base + issued));
                chk("read_bank",  32'(xsel[k]), 32'(sel));
                chk("read_count", 32'(issued < len), 1);
                issued++;
            end
            if (hold) begin
                chk("hold_valid", 32'(ov[k]),    1);
                chk("hold_data",  32'(odata[k]), 32'(hold_d));
                chk("hold_idx",   32'(idx[k]),   32'(hold_i));
            end
            if (ov[k] === 1'b1 && r) begin
                chk("out_data", 32'(odata[k]), 32'(ram[k][sel][base + popped]));
                chk("out_idx",  32'(idx[k]),   32'(popped));
                chk("out_last", 32'(last[k]),  32'(popped == len - 1));
                if (mode == 0) chk("hs_cycle", 32'(c), 32'(popped + 3));
                popped++;
                if (popped == len) last_hs = c;
            end
            chk("occupancy", 32'((issued - popped) <= 2), 1);
            if (mode == 1 && c == 20) chk("stalled_reads", 32'(issued), 2);
            hold   = (ov[k] === 1'b1) && !r;
            hold_d = odata[k];
            hold_i = idx[k];
            if (rv[k] && c > 0 && (busy_e || done_e)) err_exp[k] = 1'b1;
            if (c == rst_at) err_exp[k] = 1'b0;
            if (done_e) fin = 1;
        end
        if (!fin) chk("drain_timeout", 0, 1);
        else if (rst_at < 0) chk("word_count", 32'(popped), 32'(len));
    endtask

    initial begin
        len_of  = '{10, 10, 1};
        base_of = '{0, 4, 0};
        for (int j = 0; j < 3; j++) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 256; a++) ram[j][b][a] = 16'($urandom);
            rst[j] = 1'b1; rv[j] = 1'b0; xs[j] = 1'b0; rdy[j] = 1'b0;
            err_exp[j] = 1'b0;
        end
        for (int i = 0; i < 10; i++) ram[0][0][i] = 16'(16'h100 + i);
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) rst[j] = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) chk_zero(j, "reset");

        run_drain(0, 1'b0, 0, -1, -1);
        run_drain(0, 1'b0, 1, -1, -1);
        run_drain(0, 1'b1, 2, -1, -1);
        run_drain(1, 1'b1, 0, -1, -1);
        run_drain(1, 1'b0, 3, -1, -1);
        run_drain(2, 1'b0, 0, -1, -1);
        run_drain(2, 1'b1, 3, -1, -1);
        run_drain(0, 1'b0, 0, 5, -1);
        run_drain(0, 1'b1, 2, -1, -1);
        run_drain(0, 1'b0, 0, -1, 6);
        run_drain(0, 1'b0, 0, 13, -1);
        run_drain(0, 1'b1, 3, -1, -1);
        for (int i = 0; i < 4; i++)
            run_drain(int'($urandom_range(0, 2)), 1'($urandom), 3, -1, -1);

        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) rv[j] = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlp_result_reader.md
Name: mlp_result_reader

Overview:
- Drains the final-layer output vector of the MLP datapath from the activation (X) buffer once the MLP controller signals result_valid.
- It is the read-side counterpart of the controller's StoreX write path. It issues X-buffer reads on a dedicated read port and presents the results as a valid/ready stream to the host.
- A 2-entry prefetch FIFO sustains one word per cycle and absorbs the 1-cycle RAM read latency under backpressure.

Parameters:
- DATA_W, 16, width of one activation word.
- ADDR_W, 8, X-buffer address width.
- OUT_LEN, 10, number of result words per inference (1..2^ADDR_W-RES_BASE).
- RES_BASE, 0, address of the first result word within the selected bank.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- result_valid_i  input  1  one-cycle pulse from the MLP controller: result stored in the X buffer.
- x_sel_i  input  1  bank holding the result; sampled with result_valid_i.
- busy_o  output  1  high from the accepted trigger until done.
- x_ren_o  output  1  X-buffer read enable.
- x_sel_o  output  1  bank select for the read (latched x_sel_i).
- x_addr_o  output  ADDR_W  read address.
- x_rdata_i  input  DATA_W  read data, valid exactly one cycle after x_ren_o.
- out_valid_o  output  1  stream valid.
- out_ready_i  input  1  stream ready.
- out_data_o  output  DATA_W  result word.
- out_idx_o  output  ADDR_W  index 0..OUT_LEN-1 of out_data_o.
- out_last_o  output  1  high with the index OUT_LEN-1 word.
- done_o  output  1  one-cycle pulse after the last handshake.
- err_o  output  1  sticky; trigger arrived while busy.

Behaviour:
Reset:
- On rst_i (synchronous, active-high): all outputs 0, state Idle, FIFO empty, counters 0, err_o cleared.
- Reset mid-drain aborts immediately. No further x_ren_o and no done_o are produced. An in-flight read return is discarded.

States: Idle, Read, Drain.
- Idle: on result_valid_i=1 in cycle 0, latch x_sel_i, clear issue, pop and index counters, set busy_o, go to Read.
- Read: reads are issued until issue_cnt==OUT_LEN, then go to Drain.
- Drain: wait for the last handshake. Then done_o=1 for one cycle, busy_o=0 in that same cycle, go to Idle.
- busy_o and done_o are registered.

Issue rule (per cycle, in Read):
- x_ren_o=1 iff issue_cnt<OUT_LEN and (fifo_count + inflight - pop_this_cycle) < 2.
- Definitions: inflight = x_ren_o of the previous cycle; pop = out_valid_o & out_ready_i.
- x_addr_o = RES_BASE + issue_cnt; x_sel_o = latched bank.
- x_ren_o=0 in Idle and Drain.

FIFO and stream:
- x_rdata_i is pushed into the FIFO at the end of the cycle following x_ren_o.
- out_valid_o = FIFO not empty (registered storage); out_data_o = FIFO head.
- Push and pop in the same cycle are allowed. Overflow is impossible by the issue rule; the bench asserts this.
- out_valid_o, once high, holds with stable data and index until accepted.
- out_idx_o counts pops. out_last_o = (out_idx_o == OUT_LEN-1) & out_valid_o.

Latency and throughput:
- Trigger in cycle 0: first x_ren_o in cycle 1, first out_valid_o in cycle 3.
- With out_ready_i held 1: one word per cycle, last handshake in cycle OUT_LEN+2, done_o in cycle OUT_LEN+3.

Boundary conditions:
- result_valid_i while busy_o=1 (including the done_o cycle): ignored, err_o set to 1.
- result_valid_i in the cycle after done_o: accepted normally.
- OUT_LEN=1: single read, out_last_o with the first word.
- Address arithmetic is ADDR_W bits with no wrap; the parameter range guarantees no wrap.

Test Plan:
1. Bank 0 preloaded with value 0x100+i at address i; OUT_LEN=10; out_ready_i=1; pulse result_valid_i -> x_ren_o cycles 1..10 at addresses 0..9; out_data_o 0x100..0x109 in cycles 3..12; out_last_o in cycle 12; done_o in cycle 13.
2. Same data with out_ready_i held 0 for 20 cycles after the trigger -> exactly 2 reads issued (addr 0,1), then x_ren_o=0. Release ready -> all 10 words in order, none lost or duplicated.
3. out_ready_i toggling 1,0,1,0 -> 10 handshakes with indices 0..9 in order. Data is stable while valid and not ready. FIFO count never exceeds 2.
4. x_sel_i=1 at trigger, RES_BASE=4 -> x_sel_o=1, addresses 4..13; bank 1 data returned.
5. Second result_valid_i at cycle 5 of a drain -> ignored; err_o=1 and stays 1; the drain completes unaffected.
6. rst_i asserted in cycle 6 of a drain -> next cycle all outputs 0, no done_o. A new trigger afterwards drains a full 10 words correctly.
